// File: rtl/tof_frame_collector_pkg.sv
// -----------------------------------------------------------------------------
// tof_pkg
// Shared constants, the collector FSM state type and the BRAM address helper
// for the ToF frame collector.
//
// Contents:
//   NUM_SENS        number of 8x8 ToF sensors feeding the collector
//   ZONES           zones per sensor (8 rows x 8 cols)
//   SENS_ADDR_W     sensor-data BRAM address width ({sensor, row, col})
//   SENS_W / ZONE_W index widths for sensor and zone
//   collect_state_t collector FSM states
//   zone_to_addr()  maps (sensor, zone) to the BRAM word address
// -----------------------------------------------------------------------------
package tof_pkg;

   localparam int NUM_SENS    = 8;
   localparam int ZONES       = 64;
   localparam int SENS_ADDR_W = 9;
   localparam int SENS_W      = 3;
   localparam int ZONE_W      = 6;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      PUBLISH = 2'd2,
      HOLD    = 2'd3
   } collect_state_t;

   // zone = row*8 + col, so zone[5:3] is the row and zone[2:0] the column.
   function automatic logic [SENS_ADDR_W-1:0] zone_to_addr(
      input logic [SENS_W-1:0] sensor,
      input logic [ZONE_W-1:0] zone
   );
      return {sensor, zone[5:3], zone[2:0]};
   endfunction

endpackage

// File: rtl/tof_frame_collector_if.sv
// -----------------------------------------------------------------------------
// tof_frame_collector_if
// Bundles the sample input stream, the sensor-data BRAM write port and the
// frame status outputs of the ToF frame collector.
//
// Handshake: a sample transfers on every rising clock edge where s_valid and
// s_ready are both high. The source must hold s_sensor/s_zone/s_distance/
// s_status_ok stable while s_valid is high and s_ready is low; s_ready does
// not depend on s_valid.
//
// Signals:
//   s_valid, s_ready        sample handshake
//   s_sensor, s_zone        sensor 0..7, zone 0..63 (row*8 + col)
//   s_distance, s_status_ok distance sample and target-status flag
//   bram_we/addr/wdata      BRAM write port (one-cycle write strobe)
//   drdy                    full frame present in BRAM (level)
//   seq_err                 one-cycle pulse on an out-of-order sample
//   sens_done               per-sensor frame-complete mask
//   frame_count             completed frames (wraps)
//
// Modports: master = sample source / frame consumer, slave = collector.
// -----------------------------------------------------------------------------
interface tof_frame_collector_if #(
   parameter int DATA_W = 16
);
   import tof_pkg::*;

   logic                   s_valid;
   logic                   s_ready;
   logic [SENS_W-1:0]      s_sensor;
   logic [ZONE_W-1:0]      s_zone;
   logic [DATA_W-1:0]      s_distance;
   logic                   s_status_ok;

   logic                   bram_we;
   logic [SENS_ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0]      bram_wdata;

   logic                   drdy;
   logic                   seq_err;
   logic [NUM_SENS-1:0]    sens_done;
   logic [7:0]             frame_count;

   modport master (
      output s_valid, s_sensor, s_zone, s_distance, s_status_ok,
      input  s_ready,
      input  bram_we, bram_addr, bram_wdata,
      input  drdy, seq_err, sens_done, frame_count
   );

   modport slave (
      input  s_valid, s_sensor, s_zone, s_distance, s_status_ok,
      output s_ready,
      output bram_we, bram_addr, bram_wdata,
      output drdy, seq_err, sens_done, frame_count
   );

endinterface

// File: rtl/tof_frame_collector_zone_tracker.sv
// -----------------------------------------------------------------------------
// tof_zone_tracker
// Per-sensor ordering tracker. Holds the next expected zone and the
// frame-complete bit for one sensor, and classifies the zone offered on the
// shared sample bus as legal or out of order for this sensor.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   sel_i      a sample for this sensor is being accepted this cycle
//   clear_i    clear the done bit (frame published)
//   zone_i     zone index of the sample on the bus
//   legal_o    zone is acceptable for this sensor right now
//   done_o     registered frame-complete bit
//   done_d_o   next-state value of the done bit
// -----------------------------------------------------------------------------
module tof_zone_tracker
   import tof_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              sel_i,
   input  logic              clear_i,
   input  logic [ZONE_W-1:0] zone_i,
   output logic              legal_o,
   output logic              done_o,
   output logic              done_d_o
);

   logic [ZONE_W-1:0] exp_q, exp_d;
   logic              done_q, done_d;
   logic              legal;

   // Zone 0 always (re)starts a frame. Otherwise only the expected zone is
   // accepted, and never once the sensor has already completed its frame.
   always_comb begin
      legal = (zone_i == '0) || ((zone_i == exp_q) && !done_q);
   end

   always_comb begin
      exp_d  = exp_q;
      done_d = done_q;
      if (sel_i) begin
         if (zone_i == '0) begin
            exp_d  = ZONE_W'(1);
            done_d = 1'b0;
         end else if (legal) begin
            if (zone_i == ZONE_W'(ZONES - 1)) begin
               exp_d  = '0;
               done_d = 1'b1;
            end else begin
               exp_d = exp_q + ZONE_W'(1);
            end
         end else begin
            // Out of order: forget progress, sensor must restart at zone 0.
            exp_d  = '0;
            done_d = 1'b0;
         end
      end else if (clear_i) begin
         // exp_q is already 0 whenever done_q is set, so only done clears.
         done_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         exp_q  <= '0;
         done_q <= 1'b0;
      end else begin
         exp_q  <= exp_d;
         done_q <= done_d;
      end
   end

   assign legal_o  = legal;
   assign done_o   = done_q;
   assign done_d_o = done_d;

endmodule

// File: rtl/tof_frame_collector.sv
// -----------------------------------------------------------------------------
// tof_frame_collector
// Collects per-zone distance samples from eight 8x8 ToF sensors into the
// shared sensor-data BRAM at address {sensor, row, col}. Once every zone of
// every sensor has been written, raises drdy to the downstream read
// sequencer and holds it until the next sample is accepted.
//
// Parameters:
//   DATA_W     distance sample width
//   MAX_RANGE  saturation limit (used only with range clamping)
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   bus        tof_frame_collector_if.slave: sample stream, BRAM write port,
//              drdy / seq_err / sens_done / frame_count
//   state_o    current collector FSM state (observability)
//
// Build option:
//   TOF_RANGE_CLAMP_EN  when defined, written data is
//                       s_status_ok ? min(s_distance, MAX_RANGE) : 0;
//                       otherwise s_distance is written unmodified.
//
// Timing: a sample accepted in cycle N produces its BRAM write (or its
// seq_err pulse) in cycle N+1. The 512th legal sample moves the FSM into
// PUBLISH at N+1 (one stall cycle), and drdy is high from N+2 in HOLD.
// -----------------------------------------------------------------------------
module tof_frame_collector
   import tof_pkg::*;
#(
   parameter int                 DATA_W    = 16,
   parameter logic [DATA_W-1:0]  MAX_RANGE = DATA_W'(4000)
) (
   input  logic                   clk,
   input  logic                   rst,
   tof_frame_collector_if.slave   bus,
   output collect_state_t         state_o
);

   collect_state_t         state_q, state_d;

   logic                   ready;
   logic                   drdy;
   logic                   accept;
   logic                   sample_legal;
   logic                   publish;

   logic [NUM_SENS-1:0]    sel_vec;
   logic [NUM_SENS-1:0]    legal_vec;
   logic [NUM_SENS-1:0]    done_vec;
   logic [NUM_SENS-1:0]    done_d_vec;

   logic                   we_q;
   logic [SENS_ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0]      wdata_q, wdata_d;
   logic                   seq_err_q;
   logic [7:0]             frame_cnt_q;

   // ---------------------------------------------------------------------------
   // Per-sensor ordering trackers
   // ---------------------------------------------------------------------------
   assign accept  = bus.s_valid & ready;
   assign publish = (state_q == PUBLISH);

   for (genvar g = 0; g < NUM_SENS; g++) begin : g_trk
      assign sel_vec[g] = accept && (bus.s_sensor == SENS_W'(g));

      tof_zone_tracker u_trk (
         .clk      (clk),
         .rst      (rst),
         .sel_i    (sel_vec[g]),
         .clear_i  (publish),
         .zone_i   (bus.s_zone),
         .legal_o  (legal_vec[g]),
         .done_o   (done_vec[g]),
         .done_d_o (done_d_vec[g])
      );
   end

   assign sample_legal = legal_vec[bus.s_sensor];

   // ---------------------------------------------------------------------------
   // Collector FSM
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      ready   = 1'b0;
      drdy    = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = COLLECT;
         end
         COLLECT: begin
            ready = 1'b1;
            // Look at the next-state mask so PUBLISH lines up with the write
            // of the completing sample.
            if (&done_d_vec) begin
               state_d = PUBLISH;
            end
         end
         PUBLISH: begin
            state_d = HOLD;
         end
         HOLD: begin
            ready = 1'b1;
            drdy  = 1'b1;
            // Any accepted sample, legal or not, releases the frame; the
            // trackers process it in the same cycle.
            if (accept) begin
               state_d = COLLECT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Write data path
   // ---------------------------------------------------------------------------
`ifdef TOF_RANGE_CLAMP_EN
   always_comb begin
      wdata_d = bus.s_distance;
      if (!bus.s_status_ok) begin
         wdata_d = '0;
      end else if (bus.s_distance > MAX_RANGE) begin
         wdata_d = MAX_RANGE;
      end
   end
`else
   logic unused_status_ok;
   logic [DATA_W-1:0] unused_max_range;

   assign unused_status_ok = bus.s_status_ok;
   assign unused_max_range = MAX_RANGE;

   always_comb begin
      wdata_d = bus.s_distance;
   end
`endif

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         seq_err_q   <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         we_q      <= accept & sample_legal;
         seq_err_q <= accept & ~sample_legal;
         if (accept && sample_legal) begin
            addr_q  <= zone_to_addr(bus.s_sensor, bus.s_zone);
            wdata_q <= wdata_d;
         end
         if (publish) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.s_ready     = ready;
   assign bus.bram_we     = we_q;
   assign bus.bram_addr   = addr_q;
   assign bus.bram_wdata  = wdata_q;
   assign bus.drdy        = drdy;
   assign bus.seq_err     = seq_err_q;
   assign bus.sens_done   = done_vec;
   assign bus.frame_count = frame_cnt_q;
   assign state_o         = state_q;

endmodule

// File: tb/tb_tof_frame_collector.sv
// -----------------------------------------------------------------------------
// tb_tof_frame_collector
// Directed bench for tof_frame_collector. The driver pushes the expected BRAM
// write (or seq_err event) for each sample into exp_q; a negedge monitor pops
// and compares whenever the DUT shows bram_we or seq_err. Timing-sensitive
// status (drdy, state, counters, reset values) is checked directly.
// -----------------------------------------------------------------------------
module tb_tof_frame_collector;
   import tof_pkg::*;

   localparam int DATA_W = 16;
   localparam int W      = 1 + SENS_ADDR_W + DATA_W;  // {err, addr, data}

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   collect_state_t state;

   tof_frame_collector_if #(.DATA_W(DATA_W)) bus ();

   tof_frame_collector #(
      .DATA_W    (DATA_W),
      .MAX_RANGE (16'd4000)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .state_o (state)
   );

   // ---------------------------------------------------------------------------
   // Clock
   // ---------------------------------------------------------------------------
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   int          n_cmp = 0;
   int          n_err = 0;
   logic [W-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin : monitor
      logic [W-1:0] act;
      logic [W-1:0] req;
      if (bus.bram_we || bus.seq_err) begin
         act = {bus.seq_err,
                bus.bram_we ? bus.bram_addr  : 9'd0,
                bus.bram_we ? bus.bram_wdata : 16'd0};
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output: err=%0b we=%0b addr=0x%0h data=0x%0h, expected nothing",
                     bus.seq_err, bus.bram_we, bus.bram_addr, bus.bram_wdata);
         end else begin
            req = exp_q.pop_front();
            if (act !== req || (bus.bram_we === bus.seq_err)) begin
               n_err++;
               $display("FAIL bram_write: got err=%0b we=%0b addr=0x%0h data=0x%0h, expected err=%0b addr=0x%0h data=0x%0h",
                        bus.seq_err, bus.bram_we, act[W-2 -: SENS_ADDR_W], act[DATA_W-1:0],
                        req[W-1], req[W-2 -: SENS_ADDR_W], req[DATA_W-1:0]);
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic to_drive();
      @(posedge clk);
      #1;
   endtask

   // Issues one sample and returns just after the edge that accepted it.
   task automatic send(input int s, input int z, input logic [DATA_W-1:0] d,
                       input logic ok, input logic err);
      logic [DATA_W-1:0] wd;
      int                waited;
      if (err) begin
         exp_q.push_back({1'b1, 9'd0, 16'd0});
      end else begin
`ifdef TOF_RANGE_CLAMP_EN
         wd = !ok ? 16'd0 : ((d > 16'd4000) ? 16'd4000 : d);
`else
         wd = d;
`endif
         exp_q.push_back({1'b0, zone_to_addr(SENS_W'(s), ZONE_W'(z)), wd});
      end
      bus.s_valid     = 1'b1;
      bus.s_sensor    = SENS_W'(s);
      bus.s_zone      = ZONE_W'(z);
      bus.s_distance  = d;
      bus.s_status_ok = ok;
      waited = 0;
      @(negedge clk);
      while (!bus.s_ready && waited < 20) begin
         waited++;
         @(negedge clk);
      end
      if (!bus.s_ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout: sensor %0d zone %0d not accepted in %0d cycles", s, z, waited);
      end
      @(posedge clk);
      #1;
      bus.s_valid = 1'b0;
   endtask

   task automatic send_frame_seq();
      for (int s = 0; s < NUM_SENS; s++) begin
         for (int z = 0; z < ZONES; z++) begin
            send(s, z, 16'(s * 64 + z), 1'b1, 1'b0);
         end
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_s_ready"},     32'(bus.s_ready),     32'd0);
      check({tag, "_bram_we"},     32'(bus.bram_we),     32'd0);
      check({tag, "_bram_addr"},   32'(bus.bram_addr),   32'd0);
      check({tag, "_bram_wdata"},  32'(bus.bram_wdata),  32'd0);
      check({tag, "_drdy"},        32'(bus.drdy),        32'd0);
      check({tag, "_seq_err"},     32'(bus.seq_err),     32'd0);
      check({tag, "_sens_done"},   32'(bus.sens_done),   32'd0);
      check({tag, "_frame_count"}, 32'(bus.frame_count), 32'd0);
      check({tag, "_state"},       32'(state),           32'(IDLE));
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      bus.s_valid     = 1'b0;
      bus.s_sensor    = '0;
      bus.s_zone      = '0;
      bus.s_distance  = '0;
      bus.s_status_ok = 1'b0;

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_values("reset");
      to_drive();
      rst = 1'b0;
      @(negedge clk);
      check("first_cycle_idle", 32'(state), 32'(IDLE));
      to_drive();
      check("collect_ready", 32'(bus.s_ready), 32'd1);

      // Sensor 2 out of order: 0,1,2 written, 5 rejected, then 3 rejected
      send(2, 0, 16'h0080, 1'b1, 1'b0);
      send(2, 1, 16'h0081, 1'b1, 1'b0);
      send(2, 2, 16'h0082, 1'b1, 1'b0);
      send(2, 5, 16'h0085, 1'b1, 1'b1);
      @(negedge clk);
      check("seq_err_pulse", 32'(bus.seq_err), 32'd1);
      check("seq_err_no_we", 32'(bus.bram_we), 32'd0);
      @(negedge clk);
      check("seq_err_one_cycle", 32'(bus.seq_err), 32'd0);
      to_drive();
      send(2, 3, 16'h0083, 1'b1, 1'b1);
      @(negedge clk);
      check("err_drdy_low", 32'(bus.drdy), 32'd0);
      check("err_sens_done", 32'(bus.sens_done), 32'd0);
      to_drive();

      // Sequential full frame
      for (int s = 0; s < NUM_SENS; s++) begin
         for (int z = 0; z < ZONES; z++) begin
            send(s, z, 16'(s * 64 + z), 1'b1, 1'b0);
         end
         if (s == 0) begin
            @(negedge clk);
            check("sens0_done", 32'(bus.sens_done), 32'h01);
            to_drive();
         end
      end
      @(negedge clk);
      check("seq_publish_state", 32'(state), 32'(PUBLISH));
      check("seq_publish_drdy",  32'(bus.drdy), 32'd0);
      check("seq_publish_stall", 32'(bus.s_ready), 32'd0);
      @(negedge clk);
      check("seq_drdy",        32'(bus.drdy), 32'd1);
      check("seq_hold_state",  32'(state), 32'(HOLD));
      check("seq_frame_count", 32'(bus.frame_count), 32'd1);
      check("seq_sens_done",   32'(bus.sens_done), 32'd0);
      check("seq_hold_ready",  32'(bus.s_ready), 32'd1);

      // Release from HOLD with sensor 4 zone 0
      to_drive();
      send(4, 0, 16'h0abc, 1'b1, 1'b0);
      @(negedge clk);
      check("release_drdy",  32'(bus.drdy), 32'd0);
      check("release_we",    32'(bus.bram_we), 32'd1);
      check("release_addr",  32'(bus.bram_addr), 32'h100);
      check("release_state", 32'(state), 32'(COLLECT));
      to_drive();

      // Round-robin interleave, zone by zone
      for (int z = 0; z < ZONES; z++) begin
         for (int s = 0; s < NUM_SENS; s++) begin
            send(s, z, 16'(s * 64 + z), 1'b1, 1'b0);
         end
      end
      @(negedge clk);
      check("rr_publish_state", 32'(state), 32'(PUBLISH));
      check("rr_publish_stall", 32'(bus.s_ready), 32'd0);
      @(negedge clk);
      check("rr_drdy",        32'(bus.drdy), 32'd1);
      check("rr_frame_count", 32'(bus.frame_count), 32'd2);

      // Reset after 300 samples
      to_drive();
      for (int i = 0; i < 300; i++) begin
         send(i / 64, i % 64, 16'(i), 1'b1, 1'b0);
      end
      @(negedge clk);
      check("mid_sens_done", 32'(bus.sens_done), 32'h0f);
      to_drive();
      rst = 1'b1;
      to_drive();
      check_reset_values("midrst");
      check("midrst_queue_drained", 32'(exp_q.size()), 32'd0);
      rst = 1'b0;
      to_drive();
      send_frame_seq();
      @(negedge clk);
      @(negedge clk);
      check("post_rst_drdy",        32'(bus.drdy), 32'd1);
      check("post_rst_frame_count", 32'(bus.frame_count), 32'd1);

      // Range clamp / status handling
      to_drive();
      send(0, 0, 16'd5000, 1'b1, 1'b0);
      send(1, 0, 16'd1200, 1'b0, 1'b0);
      send(1, 1, 16'd3999, 1'b1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("final_queue_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
